// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution datapath: accumulator FSM
// states, accumulator width rule and signed saturation.
package cnn_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Widest accumulator the saturation helper can take; callers
    // sign-extend their accumulator into this width.
    localparam int MaxW = 128;

    typedef struct packed {
        logic                   overflow;
        logic signed [MaxW-1:0] value;
    } sat_t;

    // Accumulator width that holds num_lanes*kernel_size full-scale
    // products without wrapping.
    function automatic int acc_width(input int bit_size, input int num_lanes,
                                     input int kernel_size);
        return bit_size + $clog2(num_lanes * kernel_size);
    endfunction

    // Clip a sign-extended acc_w-bit value to bit_size signed. When the
    // accumulator is no wider than the result, clipping can never occur.
    function automatic sat_t sat_signed(input logic signed [MaxW-1:0] x,
                                        input int acc_w, input int bit_size);
        logic signed [MaxW-1:0] max_v;
        logic signed [MaxW-1:0] min_v;
        sat_t r;
        max_v = (MaxW'(1) << (bit_size - 1)) - MaxW'(1);
        min_v = ~max_v;
        r.value    = x;
        r.overflow = 1'b0;
        if (acc_w > bit_size) begin
            if (x > max_v) begin
                r.value    = max_v;
                r.overflow = 1'b1;
            end else if (x < min_v) begin
                r.value    = min_v;
                r.overflow = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/product_adder_tree.sv
// Combinational sum of NumLanes signed products, each sign-extended to AccW
// before adding so no partial sum can wrap.
module product_adder_tree #(
    parameter int BitSize  = 32,
    parameter int NumLanes = 4,
    parameter int AccW     = 34
) (
    input  logic [NumLanes*BitSize-1:0] lanes,
    output logic [AccW-1:0]             sum
);

    // Sign-extend every lane and accumulate them into one AccW-bit total.
    always_comb begin
        logic signed [BitSize-1:0] lane;
        logic signed [AccW-1:0]    total;
        total = '0;
        lane  = '0;
        for (int k = 0; k < NumLanes; k++) begin
            lane  = lanes[k*BitSize +: BitSize];
            total = total + AccW'(lane);
        end
        sum = total;
    end

endmodule

// File: rtl/conv_window_accumulator.sv
// Accumulates KernelSize beats of lane sums into one convolution-window
// result, saturates it to BitSize signed and holds it on a valid/ready port.
module conv_window_accumulator
    import cnn_pkg::*;
#(
    parameter int BitSize    = 32,
    parameter int NumLanes   = 4,
    parameter int KernelSize = 9
) (
    input  logic                        clk,
    input  logic                        res_n,
    input  logic                        i_clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NumLanes*BitSize-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BitSize-1:0]          out_data,
    output logic                        out_overflow
);

    localparam int AccW = acc_width(BitSize, NumLanes, KernelSize);
    localparam int CntW = (KernelSize > 1) ? $clog2(KernelSize) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(KernelSize - 1);

    acc_state_t             state;
    acc_state_t             state_next;
    logic signed [AccW-1:0] acc;
    logic [CntW-1:0]        cnt;
    logic [AccW-1:0]        lane_sum_raw;
    logic signed [AccW-1:0] lane_sum;
    logic signed [AccW-1:0] total;
    logic                   accept;
    logic                   last_beat;
    logic [BitSize-1:0]     next_data;
    logic                   next_ovf;

    product_adder_tree #(
        .BitSize (BitSize),
        .NumLanes(NumLanes),
        .AccW    (AccW)
    ) u_adder (
        .lanes(in_data),
        .sum  (lane_sum_raw)
    );

    assign lane_sum  = lane_sum_raw;
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == LastCnt);
    // In HOLD the accumulator is already zero, so acc + S is also the
    // correct first partial sum of the next window.
    assign total     = acc + lane_sum;

    // Saturate the completed window sum down to the output width.
    always_comb begin
        sat_t r;
        r         = sat_signed(MaxW'(total), AccW, BitSize);
        next_data = r.value[BitSize-1:0];
        next_ovf  = r.overflow;
    end

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= ACCUM;
        else        state <= state_next;
    end

    // Next state: any accepted last beat lands in HOLD; a taken result
    // without a completing beat returns to ACCUM; clear wins over all.
    always_comb begin
        state_next = state;
        if (i_clear) begin
            state_next = ACCUM;
        end else if (accept && last_beat) begin
            state_next = HOLD;
        end else if (state == HOLD && out_ready) begin
            state_next = ACCUM;
        end
    end

    // Handshake outputs; in_ready never looks at in_valid.
    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = !i_clear && ((state == ACCUM) || out_ready);
    end

    // Beat counter and running window sum.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (i_clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last_beat) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= total;
                cnt <= cnt + CntW'(1);
            end
        end
    end

    // Result register, loaded only when a window completes.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else if (!i_clear && accept && last_beat) begin
            out_data     <= next_data;
            out_overflow <= next_ovf;
        end
    end

endmodule

// File: doc/conv_window_accumulator.md
# conv_window_accumulator

Downstream stage of the 2-bit-weight multiplier bank. Each beat takes `NumLanes` signed products, one per multiplier, already negated or zeroed by their weights. It sums the lanes and accumulates `KernelSize` beats into one convolution-window result. The result is saturated to `BitSize` signed and presented on a valid/ready output toward the activation/pooling stage.

## Interface
Parameters:
- `BitSize`, 32: width of each product lane and of the result (two's complement).
- `NumLanes`, 4: products per input beat.
- `KernelSize`, 9: beats per window, ≥1.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `res_n` in 1: reset, asynchronous, active-low.
- `i_clear` in 1: synchronous flush of the partial window and any pending output.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_data` in `NumLanes*BitSize`: lane k at bits `[k*BitSize +: BitSize]`, signed.
- `out_valid` out 1: window result held.
- `out_ready` in 1: consumer takes the result.
- `out_data` out `BitSize`: saturated window sum, signed.
- `out_overflow` out 1: the window sum was clipped; qualified by `out_valid`.

## Operation
- Internal accumulator width `AccW = BitSize + $clog2(NumLanes*KernelSize)`. Lanes are sign-extended to `AccW` before summing, so no intermediate overflow occurs.
- Beat accepted = `in_valid && in_ready`. Lane sum `S` = signed sum of the `NumLanes` lanes (combinational).
- Beat counter `cnt`, range 0..KernelSize-1. It wraps to 0 on the last beat.
- FSM states:
  - ACCUM: `in_ready = 1`, `out_valid = 0`.
    - On accept with `cnt < KernelSize-1`: `acc <= acc + S`, `cnt++`.
    - On accept with `cnt == KernelSize-1`: load `out_data`/`out_overflow` from `sat(acc + S)`, then `acc <= 0`, `cnt <= 0`, go to HOLD.
  - HOLD: `out_valid = 1`, `in_ready = out_ready`.
    - `out_ready = 0`: hold `out_data`/`out_overflow` stable; input stalls.
    - `out_ready = 1`, no accept: go to ACCUM.
    - `out_ready = 1` with accept: the beat is the first beat of the next window (`acc <= S`, `cnt <= 1`). Go to ACCUM.
    - `out_ready = 1` with accept and `KernelSize == 1`: reload `out_data` with the new result and stay in HOLD.
- `sat(x)`:
  - x > 2^(BitSize-1)-1 → max, overflow=1.
  - x < -2^(BitSize-1) → min, overflow=1.
  - otherwise x truncated, overflow=0.
- `i_clear` has priority over every other event in the same cycle. It sets `acc=0`, `cnt=0`, state ACCUM, `out_valid=0`. The beat presented in that cycle is discarded even if `in_valid` is high; `in_ready` is 0 during `i_clear`.

## Timing
- Reset (`res_n` low, asynchronous) forces:
  - state ACCUM, `acc=0`, `cnt=0`
  - `out_valid=0`, `out_data=0`, `out_overflow=0`
  - `in_ready=1` once `res_n` is released.
- Latency: `out_valid` rises on the clock edge that accepts the last beat of a window, i.e. it is visible the cycle after that beat.
- Throughput: one window per `KernelSize` accepted beats, with no bubbles while `out_ready` is held high.
- `out_data`/`out_overflow` may change only on the loading edge, on reset, or on clear (clear leaves `out_data` unchanged but deasserts `out_valid`).
- Reset or clear mid-window discards the partial sum; the next accepted beat is beat 0.
- `in_ready` depends combinationally on `out_ready` (HOLD) and `i_clear`. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `cnn_pkg`:
  - `acc_state_t` enum {ACCUM, HOLD}.
  - Function for `AccW`.
  - `sat_signed` function (width-parameterised via `AccW`/`BitSize` arguments).
- Sub-module `product_adder_tree`: parameters `BitSize`, `NumLanes`, `AccW`. It is a purely combinational sign-extending lane sum, reused later by wider kernels.
- Top contains the FSM, counter, accumulator register and output register.

## Test plan
- BitSize=8, NumLanes=4, KernelSize=3; beats {1,1,1,1}, {2,-1,0,3}, {-5,0,0,0} with `out_ready=1` → one cycle after beat 3, `out_valid=1`, `out_data=3`, `out_overflow=0`.
- Same config, all lanes 127 for 3 beats → `out_data=127`, `out_overflow=1`. All lanes -128 for 3 beats → `out_data=-128`, `out_overflow=1`.
- Backpressure: `out_ready=0` for 5 cycles after a window completes → `out_data` stable and `in_ready=0` throughout. Raising `out_ready` together with `in_valid` → the beat is accepted as beat 0 of the next window, and the next result is correct.
- Continuous stream of 12 beats, all lanes 1, with `out_ready=1` → four results of 12 each, one every 3 cycles, no stalls.
- `i_clear` asserted with `in_valid=1` after 2 beats → that beat is dropped. The following 3 beats, all lanes 2, give 24.
- `res_n` pulsed low mid-window and in HOLD → all outputs return to 0 asynchronously, and the next window sums from zero.
